// File: rtl/tdm_pkg.sv
// Shared constants and types for the 1:4 TDM demultiplexer.
package tdm_pkg;

  localparam int NSLOTS = 4;
  localparam int SLOT_W = 2;

  // HUNT waits for a start-of-frame marker; LOCK tracks slots within a frame.
  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } tdm_state_t;

endpackage : tdm_pkg

// File: rtl/tdm_demux1_4_if.sv
// Serial slot stream in, deinterleaved 4-channel frame and framing status out.
interface tdm_demux1_4_if
  import tdm_pkg::*;
#(
  parameter int W = 1
);

  // Stream protocol: one slot word is consumed on every rising edge where
  // din_valid=1 (there is no backpressure); sof qualifies the slot-0 beat and
  // is ignored whenever din_valid=0.
  logic [W-1:0]        din;
  logic                din_valid;
  logic                sof;
  logic [NSLOTS*W-1:0] y;
  logic                frame_valid;
  logic                locked;
  logic [SLOT_W-1:0]   slot;
  logic                sync_err;
  tdm_state_t          dbg_state;

  modport master (
    output din,
    output din_valid,
    output sof,
    input  y,
    input  frame_valid,
    input  locked,
    input  slot,
    input  sync_err,
    input  dbg_state
  );

  modport slave (
    input  din,
    input  din_valid,
    input  sof,
    output y,
    output frame_valid,
    output locked,
    output slot,
    output sync_err,
    output dbg_state
  );

endinterface : tdm_demux1_4_if

// File: rtl/dec2_4.sv
// 2-bit to one-hot decoder with enable; selects which staging slot captures din.
module dec2_4 (
  input  logic       en_i,
  input  logic [1:0] sel_i,
  output logic [3:0] onehot_o
);

  always_comb begin
    onehot_o = 4'b0000;
    if (en_i) begin
      onehot_o = 4'b0001 << sel_i;
    end
  end

endmodule : dec2_4

// File: rtl/tdm_demux1_4.sv
// Receive-side 1:4 TDM demultiplexer: collects four slot words per frame and
// publishes them together as one registered word.
module tdm_demux1_4
  import tdm_pkg::*;
#(
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           rst,
  tdm_demux1_4_if.slave  tdm
);

  tdm_state_t          state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic                wr_en;
  logic [SLOT_W-1:0]   wr_idx;
  logic [NSLOTS-1:0]   we;
  logic                err_d;
  logic                locked;
  logic [W-1:0]        stage_q [NSLOTS-1];
  logic [NSLOTS*W-1:0] y_q;
  logic                frame_valid_q;
  logic                sync_err_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  // Next-state logic. A sof beat always restarts a frame at slot 0, so the
  // write index is forced to 0 for it regardless of the current slot.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    wr_en   = 1'b0;
    err_d   = 1'b0;
    wr_idx  = tdm.sof ? '0 : slot_q;
    if (tdm.din_valid) begin
      case (state_q)
        HUNT: begin
          if (tdm.sof) begin
            state_d = LOCK;
            slot_d  = SLOT_W'(1);
            wr_en   = 1'b1;
          end
        end
        LOCK: begin
          if (tdm.sof) begin
            err_d  = (slot_q != '0);
            slot_d = SLOT_W'(1);
            wr_en  = 1'b1;
          end else if (slot_q == '0) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else begin
            // Slot 3 + 1 wraps to 0, which is exactly frame completion.
            wr_en  = 1'b1;
            slot_d = slot_q + SLOT_W'(1);
          end
        end
        default: begin
          state_d = HUNT;
          slot_d  = '0;
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    locked = (state_q == LOCK);
  end

  // we[0..2] steer din into staging; we[3] marks the completing slot-3 beat.
  dec2_4 u_dec (
    .en_i     (wr_en),
    .sel_i    (wr_idx),
    .onehot_o (we)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSLOTS - 1; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NSLOTS - 1; i++) begin
        if (we[i]) begin
          stage_q[i] <= tdm.din;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q           <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      if (we[NSLOTS-1]) begin
        y_q <= {tdm.din, stage_q[2], stage_q[1], stage_q[0]};
      end
      frame_valid_q <= we[NSLOTS-1];
      sync_err_q    <= err_d;
    end
  end

  assign tdm.y           = y_q;
  assign tdm.frame_valid = frame_valid_q;
  assign tdm.sync_err    = sync_err_q;
  assign tdm.locked      = locked;
  assign tdm.slot        = slot_q;
  assign tdm.dbg_state   = state_q;

endmodule : tdm_demux1_4

// File: tb/tb_tdm_demux1_4.sv
// Bench for tdm_demux1_4 (W=4): vector table, directed corner sequences and
// random stimulus against a queue-based frame model.
module tb_tdm_demux1_4;
  import tdm_pkg::*;

  localparam int W = 4;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  tdm_demux1_4_if #(.W(W)) bus ();

  tdm_demux1_4 #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .tdm (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: the current partial frame is a queue of words received
  // since the last frame marker; its length is the expected slot index.
  logic [W-1:0] m_part[$];
  bit           m_hunt;
  logic [15:0]  m_y;
  bit           m_fv;
  bit           m_err;

  task automatic model_reset();
    m_part.delete();
    m_hunt = 1'b1;
    m_y    = '0;
    m_fv   = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic model_beat(input logic v, input logic s, input logic [W-1:0] d);
    m_fv  = 1'b0;
    m_err = 1'b0;
    if (v) begin
      if (m_hunt) begin
        if (s) begin
          m_part.delete();
          m_part.push_back(d);
          m_hunt = 1'b0;
        end
      end else if (s) begin
        if (m_part.size() != 0) m_err = 1'b1;
        m_part.delete();
        m_part.push_back(d);
      end else if (m_part.size() == 0) begin
        m_err  = 1'b1;
        m_hunt = 1'b1;
      end else begin
        m_part.push_back(d);
        if (m_part.size() == 4) begin
          m_y  = {m_part[3], m_part[2], m_part[1], m_part[0]};
          m_fv = 1'b1;
          m_part.delete();
        end
      end
    end
  endtask

  // Scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_model();
    check("y", 32'(bus.y), 32'(m_y));
    check("frame_valid", 32'(bus.frame_valid), 32'(m_fv));
    check("sync_err", 32'(bus.sync_err), 32'(m_err));
    check("locked", 32'(bus.locked), 32'(!m_hunt));
    check("slot", 32'(bus.slot), 32'(m_part.size()));
    check("state", 32'(bus.dbg_state), 32'(m_hunt ? HUNT : LOCK));
    check("fv_err_exclusive", 32'(bus.frame_valid & bus.sync_err), 32'(0));
  endtask

  // Driver: present one cycle of inputs, sample #1 after the edge.
  task automatic step(input logic v, input logic s, input logic [W-1:0] d);
    bus.din_valid = v;
    bus.sof       = s;
    bus.din       = d;
    @(posedge clk);
    model_beat(v, s, d);
    #1;
    check_model();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear with no edge.
  task automatic do_reset();
    bus.din_valid = 1'b0;
    bus.sof       = 1'b0;
    bus.din       = '0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_y", 32'(bus.y), 32'(0));
    check("rst_frame_valid", 32'(bus.frame_valid), 32'(0));
    check("rst_sync_err", 32'(bus.sync_err), 32'(0));
    check("rst_locked", 32'(bus.locked), 32'(0));
    check("rst_slot", 32'(bus.slot), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         v;
    logic         s;
    logic [W-1:0] d;
    logic [15:0]  y;
    logic         fv;
    logic         err;
    logic         lk;
    logic [1:0]   sl;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic v, input logic s, input logic [W-1:0] d,
                              input logic [15:0] y, input logic fv, input logic err,
                              input logic lk, input logic [1:0] sl);
    vec_t e;
    e.v = v; e.s = s; e.d = d; e.y = y; e.fv = fv; e.err = err; e.lk = lk; e.sl = sl;
    tbl.push_back(e);
  endfunction

  int fv_cnt;
  int err_cnt;

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst     = 1'b1;
    bus.din_valid = 1'b0;
    bus.sof       = 1'b0;
    bus.din       = '0;
    model_reset();
    #1;
    check("por_y", 32'(bus.y), 32'(0));
    check("por_locked", 32'(bus.locked), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Hunt discard: non-sof beats before lock produce nothing.
    fv_cnt  = 0;
    err_cnt = 0;
    step(1'b1, 1'b0, 4'h1); err_cnt += int'(bus.sync_err);
    step(1'b1, 1'b0, 4'h2); err_cnt += int'(bus.sync_err);
    check("hunt_locked", 32'(bus.locked), 32'(0));
    step(1'b1, 1'b1, 4'h3); err_cnt += int'(bus.sync_err); fv_cnt += int'(bus.frame_valid);
    step(1'b1, 1'b0, 4'h4); err_cnt += int'(bus.sync_err); fv_cnt += int'(bus.frame_valid);
    step(1'b1, 1'b0, 4'h5); err_cnt += int'(bus.sync_err); fv_cnt += int'(bus.frame_valid);
    step(1'b1, 1'b0, 4'h6); err_cnt += int'(bus.sync_err); fv_cnt += int'(bus.frame_valid);
    check("hunt_y", 32'(bus.y), 32'h6543);
    step(1'b0, 1'b0, 4'h0); err_cnt += int'(bus.sync_err); fv_cnt += int'(bus.frame_valid);
    check("hunt_fv_count", 32'(fv_cnt), 32'(1));
    check("hunt_err_count", 32'(err_cnt), 32'(0));

    do_reset();

    // Vector table: clean, truncated, sof-only, missing sof, back-to-back.
    add(1, 1, 4'hA, 16'h0000, 0, 0, 1, 1);
    add(1, 0, 4'hB, 16'h0000, 0, 0, 1, 2);
    add(1, 0, 4'hC, 16'h0000, 0, 0, 1, 3);
    add(1, 0, 4'hD, 16'hDCBA, 1, 0, 1, 0);
    add(0, 0, 4'h0, 16'hDCBA, 0, 0, 1, 0);
    add(1, 1, 4'h1, 16'hDCBA, 0, 0, 1, 1);
    add(1, 0, 4'h2, 16'hDCBA, 0, 0, 1, 2);
    add(1, 1, 4'h9, 16'hDCBA, 0, 1, 1, 1);
    add(1, 0, 4'hA, 16'hDCBA, 0, 0, 1, 2);
    add(1, 0, 4'hB, 16'hDCBA, 0, 0, 1, 3);
    add(1, 0, 4'hC, 16'hCBA9, 1, 0, 1, 0);
    add(0, 1, 4'hF, 16'hCBA9, 0, 0, 1, 0);
    add(1, 0, 4'h7, 16'hCBA9, 0, 1, 0, 0);
    add(1, 0, 4'h8, 16'hCBA9, 0, 0, 0, 0);
    add(1, 1, 4'h3, 16'hCBA9, 0, 0, 1, 1);
    add(1, 0, 4'h4, 16'hCBA9, 0, 0, 1, 2);
    add(1, 0, 4'h5, 16'hCBA9, 0, 0, 1, 3);
    add(1, 0, 4'h6, 16'h6543, 1, 0, 1, 0);
    add(1, 1, 4'h0, 16'h6543, 0, 0, 1, 1);
    add(1, 0, 4'h1, 16'h6543, 0, 0, 1, 2);
    add(1, 0, 4'h2, 16'h6543, 0, 0, 1, 3);
    add(1, 0, 4'h3, 16'h3210, 1, 0, 1, 0);
    add(1, 1, 4'h4, 16'h3210, 0, 0, 1, 1);
    add(1, 0, 4'h5, 16'h3210, 0, 0, 1, 2);
    add(1, 0, 4'h6, 16'h3210, 0, 0, 1, 3);
    add(1, 0, 4'h7, 16'h7654, 1, 0, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].d);
      check($sformatf("vec%0d_y", i), 32'(bus.y), 32'(tbl[i].y));
      check($sformatf("vec%0d_fv", i), 32'(bus.frame_valid), 32'(tbl[i].fv));
      check($sformatf("vec%0d_err", i), 32'(bus.sync_err), 32'(tbl[i].err));
      check($sformatf("vec%0d_locked", i), 32'(bus.locked), 32'(tbl[i].lk));
      check($sformatf("vec%0d_slot", i), 32'(bus.slot), 32'(tbl[i].sl));
    end

    // Frame with bubbles (including a sof-only idle cycle) between beats.
    step(1'b1, 1'b1, 4'h8);
    step(1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b0, 4'h9);
    step(1'b0, 1'b1, 4'h5);
    step(1'b1, 1'b0, 4'hA);
    step(1'b0, 1'b0, 4'h0);
    check("gap_y_held", 32'(bus.y), 32'h7654);
    step(1'b1, 1'b0, 4'hB);
    check("gap_y", 32'(bus.y), 32'hBA98);
    check("gap_fv", 32'(bus.frame_valid), 32'(1));

    // Asynchronous reset mid-frame, then a clean frame with no stale data.
    step(1'b1, 1'b1, 4'h1);
    step(1'b1, 1'b0, 4'h2);
    do_reset();
    step(1'b1, 1'b1, 4'hF);
    step(1'b1, 1'b0, 4'hE);
    step(1'b1, 1'b0, 4'hD);
    step(1'b1, 1'b0, 4'hC);
    check("post_rst_y", 32'(bus.y), 32'hCDEF);

    // Random stimulus against the model.
    for (int n = 0; n < 600; n++) begin
      step(logic'($urandom_range(0, 9) < 8), logic'($urandom_range(0, 3) == 0),
           W'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_tdm_demux1_4

// File: doc/tdm_demux1_4.md
Name: tdm_demux1_4

Overview:
- Time-division 1:4 demultiplexer: the receive-side counterpart of the 4:1 select mux.
- Accepts a serial stream of W-bit slot words, one word per valid beat, framed by a start-of-frame marker.
- Deinterleaves each frame into four parallel channel words and presents them together as one registered 4-channel word.
- Sits downstream of a serialising mux or link, in front of per-channel logic.

Parameters:
- W, 1, width of one slot/channel word.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- din  in  W  serial slot word
- din_valid  in  1  din is valid this cycle (beat)
- sof  in  1  start of frame; meaningful only with din_valid; marks the slot-0 beat
- y  out  4*W  last complete frame; y[W-1:0] is slot 0 … y[4W-1:3W] is slot 3
- frame_valid  out  1  one-cycle pulse when y has just been updated
- locked  out  1  1 in state LOCK
- slot  out  2  index of the next expected slot (counter value)
- sync_err  out  1  one-cycle pulse on a framing violation

Behaviour:
- Reset is asynchronous and active-high, and applies at any time including mid-frame. On reset:
  - state=HUNT, slot=0, staging cleared.
  - y=0, frame_valid=0, sync_err=0, locked=0.
- Beat definition: a beat is any rising edge with din_valid=1. When din_valid=0, nothing changes except that the frame_valid and sync_err pulses deassert.
- HUNT state:
  - Beats with sof=0 are discarded.
  - A beat with sof=1 writes din to staging[0], sets slot=1 and moves to LOCK.
- LOCK state, beat with sof=0 and slot in 1..2: write staging[slot], then slot++.
- LOCK state, beat with sof=0 and slot=3 (frame completes):
  - y <= {din, staging[2], staging[1], staging[0]}.
  - frame_valid=1 for the next cycle; slot=0; remain in LOCK.
- LOCK state, beat with sof=0 and slot=0 (missing frame marker):
  - sync_err pulse; state=HUNT; data discarded; y unchanged.
- LOCK state, beat with sof=1 and slot=0: normal frame start. Write staging[0], slot=1; no error.
- LOCK state, beat with sof=1 and slot in 1..3 (truncated frame):
  - sync_err pulse; partial frame discarded; y unchanged.
  - Resynchronise immediately: staging[0]=din, slot=1, stay in LOCK.
- Latency: y and frame_valid are visible in the cycle after the edge that samples the slot-3 beat.
- Timing of outputs:
  - y holds its value between frames.
  - Back-to-back frames on consecutive cycles are supported at full rate, one beat per cycle with no bubbles.
  - frame_valid may therefore assert every 4th cycle.
- Simultaneous conditions: sof is ignored when din_valid=0, and a sof-only cycle has no effect.
- Output encoding:
  - slot wraps from 3 to 0 only through frame completion.
  - frame_valid and sync_err are never 1 in the same cycle.
- All outputs are registered, with no combinational path from inputs to outputs.
- Slot write-enable is a 1-of-4 decode of slot, gated by the beat condition.

Decomposition:
- Shared package tdm_pkg contains:
  - Localparam NSLOTS=4 and localparam SLOT_W=2.
  - A state enum tdm_state_t {HUNT, LOCK}.
- One natural sub-module, dec2_4: a 2-bit to one-hot write-enable decoder with an enable input. It is used to steer din into staging[0..2].

Test Plan:
- Reset then clean frame (W=4): beats sof=1/din=4'hA, then 4'hB, 4'hC, 4'hD on consecutive cycles -> cycle after the last beat: y=16'hDCBA, frame_valid=1 for 1 cycle, slot=0, locked=1.
- Hunt discard: after reset, beats 4'h1, 4'h2 with sof=0, then a clean frame 3,4,5,6 -> only y=16'h6543 appears; exactly one frame_valid; sync_err never asserted.
- Back-to-back plus gaps: two frames (0..3, then 4..7) at full rate, then a third frame with din_valid=0 bubbles between its beats -> frame_valid on cycles 4, 8 and after the 12th beat; y=16'h3210, 16'h7654, then the third frame's value.
- Truncated frame: sof=1/din=4'h1, 4'h2, then sof=1/din=4'h9, 4'hA, 4'hB, 4'hC -> sync_err pulse on the second sof; y=16'hCBA9; y was unchanged (previous value) before that.
- Missing sof: complete a frame, then send a beat with sof=0 -> sync_err pulse, locked=0; following sof=0 beats are ignored until the next sof.
- Async reset mid-frame: assert rst between edges after 2 beats -> outputs clear immediately, with no clock edge needed. After release, a full frame 4'hF,4'hE,4'hD,4'hC -> y=16'hCDEF and no stale slot data.
